// File: rtl/core_pkg.sv
// Shared definitions for the execute stage: operand width, M-extension
// operation encodings and the multiply/divide sequencer state encoding.
package core_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Most negative XLEN_DEF-bit value; DIV/REM of it by -1 overflows.
   localparam logic [XLEN_DEF-1:0] SIGNED_OVF = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one radix-2 shift-add multiply step or one restoring
// shift-subtract divide step per enabled cycle, on unsigned magnitudes.
module muldiv_iter_dp
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              load_div,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] acc_next,
   output logic              last
);

   localparam int CW = $clog2(XLEN);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic              div_mode;
   logic [CW-1:0]     cnt;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_diff;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_new;
   logic [2*XLEN-1:0] div_next;

   // Multiply: the low half holds the remaining multiplier bits and is
   // shifted out as the partial product grows into the high half.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
   end

   // Divide: the high half is the partial remainder, quotient bits enter
   // at the bottom as dividend bits leave the top of the low half.
   always_comb begin
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      rem_ge   = (rem_sh >= {1'b0, opnd});
      rem_diff = rem_sh - {1'b0, opnd};
      rem_new  = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      div_next = {rem_new, acc[XLEN-2:0], rem_ge};
   end

   assign acc_next = div_mode ? div_next : mul_next;
   assign last     = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (load) begin
         acc      <= {{XLEN{1'b0}}, (load_div ? a : b)};
         opnd     <= load_div ? b : a;
         div_mode <= load_div;
         cnt      <= CW'(XLEN - 1);
      end else if (step) begin
         acc <= acc_next;
         if (!last) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV-M multiply/divide execute unit: sequences the iterative datapath,
// handles signs and the divide special cases, and stalls the pipeline.
module ex_muldiv_unit
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int OP_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr_in,
   input  logic            flush,
   output logic            busy,
   output logic            stall_out,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_addr_out
);

   localparam logic [XLEN-1:0] OVF_PAT = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e state;
   md_op_e    op_sel;
   md_op_e    op_q;
   logic      neg_a_q;
   logic      neg_b_q;
   logic [4:0] rd_q;

   logic            accept;
   logic            is_div_sel;
   logic            a_signed;
   logic            b_signed;
   logic            neg_a;
   logic            neg_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] special_res;

   logic [2*XLEN-1:0] acc_next;
   logic              last;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   calc_res;

   assign op_sel = md_op_e'(op[2:0]);

   // Handshake: start is taken only when not iterating and not flushed;
   // there is no queue, so a start seen during CALC is simply lost.
   assign accept    = start && !flush && (state != MD_CALC);
   assign busy      = (state != MD_IDLE);
   assign done      = (state == MD_DONE);
   assign stall_out = accept || (state == MD_CALC);

   always_comb begin
      is_div_sel = op_sel inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      a_signed   = op_sel inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      b_signed   = op_sel inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
      neg_a      = a_signed && rs1_data[XLEN-1];
      neg_b      = b_signed && rs2_data[XLEN-1];
      mag_a      = neg_a ? -rs1_data : rs1_data;
      mag_b      = neg_b ? -rs2_data : rs2_data;
      div_zero   = is_div_sel && (rs2_data == '0);
      div_ovf    = (op_sel == MD_DIV || op_sel == MD_REM) &&
                   (rs1_data == OVF_PAT) && (rs2_data == '1);
      special    = div_zero || div_ovf;
      if (div_zero) begin
         special_res = (op_sel == MD_DIV || op_sel == MD_DIVU) ? '1 : rs1_data;
      end else begin
         special_res = (op_sel == MD_DIV) ? OVF_PAT : '0;
      end
   end

   muldiv_iter_dp #(
      .XLEN (XLEN)
   ) u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && !special),
      .step     (state == MD_CALC),
      .load_div (is_div_sel),
      .a        (mag_a),
      .b        (mag_b),
      .acc_next (acc_next),
      .last     (last)
   );

   // Fix-up works on the value the final iteration edge is about to store.
   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
      quo      = acc_next[XLEN-1:0];
      rem      = acc_next[2*XLEN-1:XLEN];
      unique case (op_q)
         MD_MUL:                       calc_res = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              calc_res = (neg_a_q ^ neg_b_q) ? -quo : quo;
         default:                      calc_res = neg_a_q ? -rem : rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= MD_IDLE;
         op_q        <= MD_MUL;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         rd_q        <= '0;
         result      <= '0;
         rd_addr_out <= '0;
      end else if (flush) begin
         state <= MD_IDLE;
      end else begin
         unique case (state)
            MD_CALC: begin
               if (last) begin
                  state       <= MD_DONE;
                  result      <= calc_res;
                  rd_addr_out <= rd_q;
               end
            end
            default: begin
               if (accept) begin
                  op_q    <= op_sel;
                  rd_q    <= rd_addr_in;
                  neg_a_q <= neg_a;
                  neg_b_q <= neg_b;
                  if (special) begin
                     state       <= MD_DONE;
                     result      <= special_res;
                     rd_addr_out <= rd_addr_in;
                  end else begin
                     state <= MD_CALC;
                  end
               end else begin
                  state <= MD_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: per-scenario tasks with hand-computed
// results and cycle timing, counted in checks/errors.
module tb_ex_muldiv_unit;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_addr_in;
   logic        flush;
   logic        busy;
   logic        stall_out;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_addr_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(
      .XLEN (32),
      .OP_W (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rd_addr_in  (rd_addr_in),
      .flush       (flush),
      .busy        (busy),
      .stall_out   (stall_out),
      .done        (done),
      .result      (result),
      .rd_addr_out (rd_addr_out)
   );

   // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
   task next_cycle;
      @(posedge clk);
      #1;
   endtask

   task check_idle_zero(input string name);
      checks++;
      if ({busy, done, stall_out, result, rd_addr_out} !== 40'd0) begin
         errors++;
         $display("FAIL %s: busy=%b done=%b stall=%b result=%h rd=%0d, required all zero",
                  name, busy, done, stall_out, result, rd_addr_out);
      end
   endtask

   task test_reset;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
      rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
      next_cycle;
      next_cycle;
      rst = 1'b0;
      #1;
      check_idle_zero("reset");
   endtask

   task run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
               input logic [4:0] rd, input logic [31:0] exp_res, input int exp_cyc,
               input string name);
      int          done_cyc;
      logic        stall_ok;
      logic [31:0] got_res;
      logic [4:0]  got_rd;
      op = o; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
      #1;
      stall_ok = (stall_out === 1'b1);
      next_cycle;
      start = 1'b0; rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
      done_cyc = -1; got_res = 'x; got_rd = 'x;
      for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
         #1;
         if (done === 1'b1) begin
            done_cyc = c;
            got_res  = result;
            got_rd   = rd_addr_out;
            if (stall_out !== 1'b0) stall_ok = 1'b0;
         end else begin
            if (stall_out !== 1'b1) stall_ok = 1'b0;
            next_cycle;
         end
      end
      checks++;
      if (done_cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, exp_cyc);
      end
      checks++;
      if (got_res !== exp_res) begin
         errors++;
         $display("FAIL %s result: got %h, required %h", name, got_res, exp_res);
      end
      checks++;
      if (got_rd !== rd) begin
         errors++;
         $display("FAIL %s rd_addr_out: got %0d, required %0d", name, got_rd, rd);
      end
      checks++;
      if (!stall_ok) begin
         errors++;
         $display("FAIL %s stall: got wrong stall_out pattern, required high until done cycle", name);
      end
      next_cycle;
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b busy=%b, required 0 0", name, done, busy);
      end
   endtask

   task test_multiply;
      run_op(MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 33, "mul_7_m3");
      run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 33, "mulhu_ones");
      run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 33, "mulhsu_ones");
      run_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 33, "mulh_ones");
      run_op(MD_MUL,    32'hFFFF_FFFD, 32'hFFFF_FFFD, 5'd14, 32'h0000_0009, 33, "mul_m3_m3");
   endtask

   task test_divide;
      run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(MD_REM,  32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(MD_DIVU, 32'd100,       32'd7, 5'd17, 32'd14,        33, "divu_100_7");
      run_op(MD_REMU, 32'd100,       32'd7, 5'd18, 32'd2,         33, "remu_100_7");
   endtask

   task test_special;
      run_op(MD_DIVU, 32'd100,       32'd0,         5'd19, 32'hFFFF_FFFF, 1, "divu_by_zero");
      run_op(MD_REMU, 32'd100,       32'd0,         5'd20, 32'd100,       1, "remu_by_zero");
      run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1, "div_overflow");
      run_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 1, "rem_overflow");
   endtask

   // Previous result is 0 from rem_overflow, so seed a nonzero one first.
   task test_flush;
      logic        early_done;
      int          done_cyc;
      logic [31:0] got_res;
      run_op(MD_REMU, 32'd1000, 32'd7, 5'd2, 32'd6, 33, "flush_seed");
      op = MD_MUL; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_addr_in = 5'd3; start = 1'b1;
      next_cycle;
      start = 1'b0;
      early_done = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         #1;
         if (done !== 1'b0) early_done = 1'b1;
         next_cycle;
      end
      flush = 1'b1; start = 1'b1; op = MD_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd4;
      #1;
      if (done !== 1'b0) early_done = 1'b1;
      next_cycle;
      flush = 1'b0; start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || early_done) begin
         errors++;
         $display("FAIL flush_idle: got busy=%b done=%b early_done=%b, required 0 0 0",
                  busy, done, early_done);
      end
      checks++;
      if (result !== 32'd6 || rd_addr_out !== 5'd2) begin
         errors++;
         $display("FAIL flush_hold: got result=%h rd=%0d, required 00000006 rd=2", result, rd_addr_out);
      end
      op = MD_DIVU; rs1_data = 32'd1000; rs2_data = 32'd10; rd_addr_in = 5'd6; start = 1'b1;
      next_cycle;
      start = 1'b0;
      done_cyc = -1; got_res = 'x;
      for (int c = 12; c <= 80 && done_cyc < 0; c++) begin
         #1;
         if (done === 1'b1) begin
            done_cyc = c;
            got_res  = result;
         end else begin
            next_cycle;
         end
      end
      checks++;
      if (done_cyc != 44) begin
         errors++;
         $display("FAIL flush_restart done_cycle: got %0d, required 44", done_cyc);
      end
      checks++;
      if (got_res !== 32'd100) begin
         errors++;
         $display("FAIL flush_restart result: got %h, required 00000064", got_res);
      end
      next_cycle;
   endtask

   task test_back_to_back;
      int          d1;
      int          d2;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        done_after;
      op = MD_MULHU; rs1_data = 32'h0001_0000; rs2_data = 32'h0001_0000; rd_addr_in = 5'd7; start = 1'b1;
      next_cycle;
      op = MD_REMU; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr_in = 5'd8;
      d1 = -1; d2 = -1; r1 = 'x; r2 = 'x; a1 = 'x; a2 = 'x; done_after = 1'b0;
      for (int c = 1; c <= 100 && d2 < 0; c++) begin
         #1;
         if (done === 1'b1) begin
            if (d1 < 0) begin
               d1 = c; r1 = result; a1 = rd_addr_out;
            end else begin
               d2 = c; r2 = result; a2 = rd_addr_out;
            end
         end
         if (c == d1 + 1 && d1 > 0 && done !== 1'b0) done_after = 1'b1;
         if (d2 < 0) next_cycle;
         if (d1 > 0) start = 1'b0;
      end
      checks++;
      if (d1 != 33 || r1 !== 32'd1 || a1 !== 5'd7) begin
         errors++;
         $display("FAIL b2b_first: got cycle=%0d result=%h rd=%0d, required 33 00000001 7", d1, r1, a1);
      end
      checks++;
      if (d2 != 66 || r2 !== 32'd6 || a2 !== 5'd8) begin
         errors++;
         $display("FAIL b2b_second: got cycle=%0d result=%h rd=%0d, required 66 00000006 8", d2, r2, a2);
      end
      checks++;
      if (done_after) begin
         errors++;
         $display("FAIL b2b_pulse: got done high in cycle after first done, required low");
      end
      next_cycle;
   endtask

   task test_reset_mid;
      logic stray_done;
      op = MD_MUL; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_addr_in = 5'd9; start = 1'b1;
      next_cycle;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) next_cycle;
      rst = 1'b1;
      next_cycle;
      rst = 1'b0;
      #1;
      check_idle_zero("reset_mid");
      stray_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done !== 1'b0) stray_done = 1'b1;
         next_cycle;
      end
      checks++;
      if (stray_done) begin
         errors++;
         $display("FAIL reset_mid_no_done: got a done pulse after reset, required none");
      end
   endtask

   initial begin
      test_reset;
      test_multiply;
      test_divide;
      test_special;
      test_flush;
      test_back_to_back;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised iterative multiply/divide execute unit that adds the RV32M (generally RV-XLEN M) instruction class to the EX stage.
- Sits beside the ALU inside the execute stage.
- Accepts one operation from the ID/EX buffer and holds the pipeline via a stall signal while it iterates.
- Presents a registered result plus destination register address to the EX/MA buffer, with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width in bits (any even value ≥ 8).
- OP_W, 3, width of the operation select.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation this cycle
- op  in  OP_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  XLEN  operand A (multiplicand / dividend)
- rs2_data  in  XLEN  operand B (multiplier / divisor)
- rd_addr_in  in  5  destination register
- flush  in  1  abort any operation in flight
- busy  out  1  unit not idle
- stall_out  out  1  hold IF/ID/EX buffers
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  operation result
- rd_addr_out  out  5  destination register of result

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge where rst=1. After reset: FSM in IDLE; busy=0, done=0, stall_out=0, result=0, rd_addr_out=0. Reset mid-operation discards it with no done.
- FSM states:
  - IDLE, CALC, DONE. busy = (state != IDLE).
  - A start is accepted when start=1, flush=0, and state is IDLE or DONE. Start in CALC is ignored; no queueing.
- Accept at edge E0, end of cycle N:
  - Latch op, rd_addr_in, operand magnitudes and sign flags.
  - Special case: divisor=0, or signed overflow (DIV/REM with A = -2^(XLEN-1), B = -1). Go to DONE; done=1 in cycle N+1.
  - Otherwise go to CALC. Iteration counter loads XLEN-1 and decrements each edge. Exit to DONE when it reaches 0, after exactly XLEN iteration edges. done=1 in cycle N+XLEN+1.
- Datapath:
  - Multiply: radix-2 shift-add on |A|,|B| into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract on |A|,|B|, giving quotient and remainder.
- Sign rules:
  - MUL, MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Product negated if signs differ. MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
- Special results:
  - Divide by zero: quotient all-ones; remainder = dividend (raw A).
  - Signed overflow: quotient = -2^(XLEN-1); remainder = 0.
- DONE state:
  - result and rd_addr_out are registered on entry to DONE, valid in the same cycle as done.
  - Both hold their value until the next entry to DONE.
  - done is high for exactly one cycle.
  - Next state: IDLE, or CALC/DONE if a start is accepted in that cycle (back-to-back).
- stall_out = accepted_start | (state == CALC). It is low in the DONE cycle, so the EX/MA buffer captures result on that edge.
- flush:
  - Any state goes to IDLE at the next edge; done is suppressed.
  - flush has priority over start in the same cycle; that start is dropped.
  - result and rd_addr_out keep their old values.
- rst has priority over flush and start.

Decomposition:
- Shared package core_pkg holds:
  - XLEN default.
  - muldiv op encodings MD_MUL … MD_REMU.
  - FSM state encoding.
  - Constant for the signed-overflow pattern.
- Sub-module muldiv_iter_dp holds the shared accumulator, shift/add/subtract step and counter. The FSM, sign pre-processing and sign/special fix-up stay in the top.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), start cycle 0 → stall_out high in cycles 0-32; done=1 only in cycle 33; result 0xFFFFFFEB; rd_addr_out = rd_addr_in.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULH of the same operands → 0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, each with done in cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, each with done in cycle 1.
- Start at cycle 0, flush at cycle 10 → busy=0 from cycle 11, no done ever. Start in the cycle-10 flush is ignored. Start at cycle 11 completes normally with done in cycle 44.
- Start held high during CALC → ignored. Start in the DONE cycle → accepted back-to-back, next done 33 cycles later. rst=1 at cycle 5 → all outputs 0 from cycle 6.
